// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and constants for the FIFO write-port arbiter
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int STAT_W = 16;

endpackage

// File: rtl/fifo_rr_pick.sv
// rtl/fifo_rr_pick.sv - combinational circular priority picker, search starts at rr_ptr+1
module fifo_rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr_ptr,
  output logic            found,
  output logic [IW-1:0]   sel
);

  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    sel   = rr_ptr;
    // Walk from the lowest priority up so the nearest candidate after rr_ptr wins last.
    for (int k = NREQ; k >= 1; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req[idx]) begin
        found = 1'b1;
        sel   = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter for the FIFO write port
// Optional per-requester beat counters (stat_beats) are enabled by FIFO_ARB_STATS_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NREQ      = 4,
  parameter  int DSIZE     = 8,
  parameter  int MAX_BURST = 4,
  localparam int IW        = $clog2(NREQ),
  localparam int CW        = $clog2(MAX_BURST + 1)
) (
  input  logic                   wclk,
  input  logic                   wrst_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DSIZE-1:0]  req_data,
  output logic [NREQ-1:0]        req_ready,
  output logic                   winc,
  output logic [DSIZE-1:0]       wdata,
  input  logic                   wfull,
  output logic [IW-1:0]          grant_id,
  output logic                   busy
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NREQ*STAT_W-1:0] stat_beats
`endif
);

  arb_state_t    state, state_nxt;
  logic [IW-1:0] rr_ptr, rr_nxt;
  logic [IW-1:0] owner, owner_nxt;
  logic [CW-1:0] beat_cnt, beat_nxt;
  logic [IW-1:0] sel, src;
  logic          found, xfer;

  fifo_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req    (req_valid),
    .rr_ptr (rr_ptr),
    .found  (found),
    .sel    (sel)
  );

  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_ptr;
    owner_nxt = owner;
    beat_nxt  = beat_cnt;
    xfer      = 1'b0;
    src       = owner;
    grant_id  = owner;
    case (state)
      IDLE: begin
        if (found) begin
          grant_id = sel;
          src      = sel;
          if (!wfull) begin
            xfer      = 1'b1;
            owner_nxt = sel;
            beat_nxt  = CW'(1);
            if (MAX_BURST == 1) rr_nxt = sel;
            else                state_nxt = BURST;
          end
        end
      end
      BURST: begin
        if (req_valid[owner]) begin
          if (!wfull) begin
            xfer = 1'b1;
            if (beat_cnt == CW'(MAX_BURST - 1)) begin
              state_nxt = IDLE;
              rr_nxt    = owner;
              beat_nxt  = '0;
            end else begin
              beat_nxt = beat_cnt + CW'(1);
            end
          end
        end else begin
          // Owner went quiet: give up the grant, costing one idle cycle.
          state_nxt = IDLE;
          rr_nxt    = owner;
          beat_nxt  = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign winc      = xfer;
  assign wdata     = req_data[src*DSIZE +: DSIZE];
  assign req_ready = xfer ? (NREQ'(1) << src) : '0;
  assign busy      = (state == BURST);

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state    <= IDLE;
      rr_ptr   <= IW'(NREQ - 1);
      owner    <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_nxt;
      owner    <= owner_nxt;
      beat_cnt <= beat_nxt;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  for (genvar g = 0; g < NREQ; g++) begin : g_stat
    logic [STAT_W-1:0] cnt;
    always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n)                      cnt <= '0;
      else if (req_ready[g] && cnt != '1) cnt <= cnt + STAT_W'(1);
    end
    assign stat_beats[g*STAT_W +: STAT_W] = cnt;
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed and random checks of fifo_wr_arbiter against a reference model
module tb_fifo_wr_arbiter;

  localparam int NREQ      = 4;
  localparam int DSIZE     = 8;
  localparam int MAX_BURST = 4;
  localparam int IW        = 2;

  logic                  wclk = 1'b0;
  logic                  wrst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  winc;
  logic [DSIZE-1:0]      wdata;
  logic                  wfull;
  logic [IW-1:0]         grant_id;
  logic                  busy;
`ifdef FIFO_ARB_STATS_EN
  logic [NREQ*16-1:0]    stat_beats;
`endif

  always #5 wclk = ~wclk;

  fifo_wr_arbiter #(
    .NREQ      (NREQ),
    .DSIZE     (DSIZE),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .wclk      (wclk),
    .wrst_n    (wrst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .winc      (winc),
    .wdata     (wdata),
    .wfull     (wfull),
    .grant_id  (grant_id),
    .busy      (busy)
`ifdef FIFO_ARB_STATS_EN
    ,
    .stat_beats(stat_beats)
`endif
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: who holds the port, how many beats it has used, last served requester.
  int m_rr, m_owner, m_beats;
  bit m_burst;
  int m_stat [NREQ];

  logic [NREQ-1:0] s_ready;
  logic            s_winc, s_busy;
  logic [IW-1:0]   s_gid;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rr    = NREQ - 1;
    m_owner = 0;
    m_beats = 0;
    m_burst = 0;
    for (int i = 0; i < NREQ; i++) m_stat[i] = 0;
  endtask

  function automatic int model_pick();
    for (int k = 1; k <= NREQ; k++) begin
      if (req_valid[(m_rr + k) % NREQ]) return (m_rr + k) % NREQ;
    end
    return -1;
  endfunction

  // Called at a negedge with inputs applied; checks, clocks, updates the model, returns at next negedge.
  task automatic run_cycle();
    int s, eg, e_src;
    bit e_xfer;
    #2;
    e_xfer = 0;
    e_src  = m_owner;
    eg     = m_owner;
    if (!m_burst) begin
      s = model_pick();
      if (s >= 0) begin
        eg     = s;
        e_src  = s;
        e_xfer = !wfull;
      end
    end else begin
      e_xfer = req_valid[m_owner] && !wfull;
    end
    s_ready = req_ready;
    s_winc  = winc;
    s_busy  = busy;
    s_gid   = grant_id;
    chk("winc", winc, e_xfer);
    chk("req_ready", req_ready, e_xfer ? (64'd1 << e_src) : 64'd0);
    chk("grant_id", grant_id, eg);
    chk("busy", busy, m_burst);
    if (e_xfer) chk("wdata", wdata, req_data[e_src*DSIZE +: DSIZE]);
    @(posedge wclk);
    if (e_xfer && m_stat[e_src] < 65535) m_stat[e_src]++;
    if (!m_burst) begin
      if (e_xfer) begin
        m_owner = e_src;
        m_beats = 1;
        if (MAX_BURST == 1) m_rr = e_src;
        else                m_burst = 1;
      end
    end else if (!req_valid[m_owner]) begin
      m_burst = 0;
      m_rr    = m_owner;
      m_beats = 0;
    end else if (e_xfer) begin
      m_beats++;
      if (m_beats == MAX_BURST) begin
        m_burst = 0;
        m_rr    = m_owner;
        m_beats = 0;
      end
    end
    @(negedge wclk);
    for (int i = 0; i < NREQ; i++)
      if (s_ready[i]) req_data[i*DSIZE +: DSIZE] = DSIZE'($urandom);
  endtask

  task automatic do_reset();
    req_valid = '0;
    wfull     = 1'b0;
    wrst_n    = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_winc", winc, 0);
    chk("rst_ready", req_ready, 0);
    @(posedge wclk);
    @(negedge wclk);
    wrst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    req_data = '0;
    for (int i = 0; i < NREQ; i++) req_data[i*DSIZE +: DSIZE] = DSIZE'($urandom);
    model_reset();
    do_reset();

    // All requesters valid: 4-beat bursts in order 0,1,2,3,0 with no gaps.
    req_valid = '1;
    for (int k = 0; k < 17; k++) begin
      run_cycle();
      chk("t1_winc", s_winc, 1);
      chk("t1_owner", s_ready, NREQ'(1) << ((k / 4) % NREQ));
    end

    // Requester 2 alone for 10 beats: bursts 4,4,2, then one bubble.
    do_reset();
    req_valid = 4'b0100;
    for (int k = 0; k < 10; k++) begin
      run_cycle();
      chk("t2_ready", s_ready, 4'b0100);
      chk("t2_busy", s_busy, (k % 4) != 0);
    end
    req_valid = '0;
    run_cycle();
    chk("t2_bubble_winc", s_winc, 0);
    chk("t2_bubble_busy", s_busy, 1);
    run_cycle();
    chk("t2_idle", s_busy, 0);

    // Requester 1 stalled by wfull mid-burst, then finishes its remaining 2 beats.
    do_reset();
    req_valid = 4'b0010;
    run_cycle();
    run_cycle();
    wfull = 1'b1;
    for (int k = 0; k < 3; k++) begin
      run_cycle();
      chk("t3_stall_winc", s_winc, 0);
      chk("t3_stall_ready", s_ready, 0);
      chk("t3_stall_gid", s_gid, 1);
      chk("t3_stall_busy", s_busy, 1);
    end
    wfull = 1'b0;
    for (int k = 0; k < 2; k++) begin
      run_cycle();
      chk("t3_resume", s_ready, 4'b0010);
      chk("t3_resume_busy", s_busy, 1);
    end
    run_cycle();
    chk("t3_end_busy", s_busy, 0);

    // Owner 3 drops after one beat: bubble, then requester 0 ahead of 2.
    do_reset();
    req_valid = 4'b1000;
    run_cycle();
    chk("t4_first", s_ready, 4'b1000);
    req_valid = 4'b0101;
    run_cycle();
    chk("t4_bubble_winc", s_winc, 0);
    chk("t4_bubble_gid", s_gid, 3);
    chk("t4_bubble_busy", s_busy, 1);
    run_cycle();
    chk("t4_next", s_ready, 4'b0001);
    chk("t4_next_gid", s_gid, 0);

    // Asynchronous reset in the middle of a burst from requester 2.
    do_reset();
    req_valid = 4'b0100;
    run_cycle();
    run_cycle();
    req_valid = 4'b1111;
    #1;
    wrst_n = 1'b0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_gid", grant_id, 0);
    @(posedge wclk);
    @(negedge wclk);
    wrst_n = 1'b1;
    model_reset();
    run_cycle();
    chk("t5_first", s_ready, 4'b0001);

    // Random traffic honouring the hold-until-ready rule.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NREQ; i++)
        if (!req_valid[i] || s_ready[i]) req_valid[i] = ($urandom % 4) != 0;
      wfull = ($urandom % 5) == 0;
      run_cycle();
    end

`ifdef FIFO_ARB_STATS_EN
    for (int i = 0; i < NREQ; i++) chk("stat_rand", stat_beats[i*16 +: 16], m_stat[i]);
    do_reset();
    req_valid = 4'b0010;
    for (int c = 0; c < 70000; c++) run_cycle();
    for (int i = 0; i < NREQ; i++) chk("stat_model", stat_beats[i*16 +: 16], m_stat[i]);
    chk("stat_sat", stat_beats[16 +: 16], 16'hFFFF);
    chk("stat_zero0", stat_beats[0 +: 16], 0);
    chk("stat_zero2", stat_beats[32 +: 16], 0);
    chk("stat_zero3", stat_beats[48 +: 16], 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
